vga_scanout: RTL and testbench
==============================

// Module: vga_scanout
// PURPOSE
//  VGA timing generator and pixel sink for the tetris display path. It produces the raster
//  coordinates pix_x_o/pix_y_o that the field renderers consume, and takes back their
//  vga_data/vga_data_en a fixed DATA_LAT cycles later. It delays hsync/vsync/de to match that
//  latency and drives registered RGB and sync pins. It also emits a vblank_start_o pulse so
//  game logic can update game data tear-free.
// PARAMETERS
//  PIX_WIDTH 12          width of pixel coordinate counters
//  H_ACTIVE 1280 / H_FP 48 / H_SYNC 112 / H_BP 248    horizontal timing, in pixels
//  V_ACTIVE 1024 / V_FP 1 / V_SYNC 3 / V_BP 38        vertical timing, in lines
//  HS_POL 1 / VS_POL 1   sync active level (1 = active-high)
//  DATA_LAT 2            cycles from pix_x_o/pix_y_o to valid vga_data_i; range 0..7
//  BG_COLOR 24'h000000   RGB driven in the active area when vga_data_en_i=0
// PORTS
//  clk            in   1          pixel clock (108 MHz for the defaults)
//  rst_n          in   1          asynchronous active-low reset
//  pix_x_o        out  PIX_WIDTH  current horizontal count, to renderers
//  pix_y_o        out  PIX_WIDTH  current vertical count, to renderers
//  vga_data_i     in   24         renderer RGB {R,G,B}; refers to coords DATA_LAT cycles earlier
//  vga_data_en_i  in   1          renderer owns this pixel
//  vblank_start_o out  1          1-cycle pulse on the first cycle of line V_ACTIVE (undelayed)
//  vga_r_o/vga_g_o/vga_b_o out 8 each   registered colour outputs
//  vga_hs_o, vga_vs_o      out 1        registered, latency-aligned syncs
//  vga_de_o       out  1          registered data enable
// BEHAVIOUR
//  - Timing totals: H_TOT=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise.
//  - Width rule: elaboration fails unless H_TOT-1 and V_TOT-1 fit in PIX_WIDTH bits.
//  - h_cnt runs 0..H_TOT-1 and wraps to 0.
//  - v_cnt increments only when h_cnt wraps, and wraps to 0 at V_TOT-1.
//  - pix_x_o=h_cnt and pix_y_o=v_cnt, both registered, with no added delay.
//  - Stage-0 signals, computed from the counters:
//    de0 = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
//    hs0 = HS_POL when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else !HS_POL
//    vs0 = the same rule on v_cnt with the V_* parameters and VS_POL
//  - de0/hs0/vs0 pass through a DATA_LAT-deep delay line. DATA_LAT=0 means a direct path.
//  - Output register:
//    rgb = de_d ? (vga_data_en_i ? vga_data_i : BG_COLOR) : 24'h0
//  - Total latency from a pix_x_o/pix_y_o value to its pins is DATA_LAT+1 cycles.
//  - Outside the active area, rgb is forced to 0 regardless of vga_data_en_i.
//  - vblank_start_o goes high when h_cnt==0 && v_cnt==V_ACTIVE. It fires exactly once per frame.
//  - Reset (asynchronous; may arrive mid-line or mid-frame):
//    counters, pix_x_o, pix_y_o = 0
//    delay line: de=0, hs/vs=inactive level
//    de_o=0, rgb=0, hs_o=!HS_POL, vs_o=!VS_POL, vblank_start_o=0
//  - First cycle after reset release: pix=(0,0).
//  - First de_o=1 appears DATA_LAT+1 cycles after reset release.
//  - No backpressure: the renderers must meet DATA_LAT every cycle.
// CONFIGURATION
//  - VGA_TEST_PATTERN_EN defined:
//    In the active area, rgb is the colour bar COLOR_BRICKS_k, with k=(aligned x)/(H_ACTIVE/8).
//    vga_data_i and vga_data_en_i are ignored.
//    Timing, latency, sync and vblank_start_o are unchanged.
//  - VGA_TEST_PATTERN_EN undefined: normal renderer path; no pattern logic is synthesized.
// STRUCTURE
//  - Shared package tetris_vga_pkg holds:
//    timing localparams for the 1280x1024@60 mode
//    rgb_t packed struct {r,g,b}
//    H_TOT/V_TOT helper functions
//  - Colour constants stay in defs.vh.
//  - One sub-module, sig_delay #(WIDTH,DEPTH): an async-reset shift register for {de,hs,vs}.
//    DEPTH=0 gives a passthrough.
// TESTING
//  Bench uses small timing: H_ACTIVE=8,FP=2,SYNC=3,BP=3 (H_TOT=16); V_ACTIVE=4,FP=1,SYNC=2,BP=1 (V_TOT=8); DATA_LAT=2.
//  1. Reset release -> pix (0,0); pix_x wraps 15->0 and pix_y increments; frame period = 128 cycles.
//  2. vga_data_i=24'hA5B6C7, en=1 for x=3 on a visible line
//     -> rgb=A5,B6,C7 with de_o=1, 3 cycles after pix_x_o=3.
//  3. en=0 in the active area -> rgb=BG_COLOR; en=1, data=FFFFFF during blanking -> rgb=0, de_o=0.
//  4. hs_o active for exactly 3 cycles; its first active cycle is 3 cycles after pix_x_o=10.
//     vs_o active for exactly 2 lines starting at line 5 (delayed 3 cycles).
//  5. vblank_start_o is a single pulse at pix=(0,4), once per frame over 3 frames.
//  6. rst_n asserted mid-line at pix=(6,2)
//     -> all outputs take reset values asynchronously; after release, the sequence restarts from (0,0).
//  Optional: with VGA_TEST_PATTERN_EN defined -> 8 bars of 1 pixel each,
//     colours COLOR_BRICKS_0..7 in order.

Source files
------------

// File: rtl/tetris_vga_pkg.sv
// Shared VGA definitions for the tetris display path: 1280x1024@60 timing, RGB type,
// timing-total helper and the brick colour set used by the optional colour-bar pattern.
package tetris_vga_pkg;

    localparam int TIM_H_ACTIVE = 1280;
    localparam int TIM_H_FP     = 48;
    localparam int TIM_H_SYNC   = 112;
    localparam int TIM_H_BP     = 248;
    localparam int TIM_V_ACTIVE = 1024;
    localparam int TIM_V_FP     = 1;
    localparam int TIM_V_SYNC   = 3;
    localparam int TIM_V_BP     = 38;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic int calc_h_tot(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int calc_v_tot(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // Brick palette, index 0..7 left to right across the colour-bar pattern.
    function automatic rgb_t brick_color(input logic [2:0] k);
        rgb_t c;
        case (k)
            3'd0:    c = 24'h00F0F0;
            3'd1:    c = 24'h0000F0;
            3'd2:    c = 24'hF0A000;
            3'd3:    c = 24'hF0F000;
            3'd4:    c = 24'h00F000;
            3'd5:    c = 24'hA000F0;
            3'd6:    c = 24'hF00000;
            3'd7:    c = 24'h808080;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_scanout_sig_delay.sv
// Async-reset shift register delaying a small bus by DEPTH clocks; DEPTH=0 is a wire.
module sig_delay #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q_o = d_i;
        end else begin : g_shift
            logic [WIDTH-1:0] sr_q [DEPTH];

            // Shift chain; every stage resets to the bus idle value.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        sr_q[i] <= RST_VAL;
                    end
                end else begin
                    sr_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        sr_q[i] <= sr_q[i-1];
                    end
                end
            end

            assign q_o = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scanout.sv
// VGA raster timing generator and pixel sink. Define VGA_TEST_PATTERN_EN to replace the
// renderer data with eight brick-coloured vertical bars (timing unchanged).
module vga_scanout
    import tetris_vga_pkg::*;
#(
    parameter int          PIX_WIDTH = 12,
    parameter int          H_ACTIVE  = TIM_H_ACTIVE,
    parameter int          H_FP      = TIM_H_FP,
    parameter int          H_SYNC    = TIM_H_SYNC,
    parameter int          H_BP      = TIM_H_BP,
    parameter int          V_ACTIVE  = TIM_V_ACTIVE,
    parameter int          V_FP      = TIM_V_FP,
    parameter int          V_SYNC    = TIM_V_SYNC,
    parameter int          V_BP      = TIM_V_BP,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1,
    parameter int          DATA_LAT  = 2,
    parameter logic [23:0] BG_COLOR  = 24'h000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PIX_WIDTH-1:0] pix_x_o,
    output logic [PIX_WIDTH-1:0] pix_y_o,
    input  logic [23:0]          vga_data_i,
    input  logic                 vga_data_en_i,
    output logic                 vblank_start_o,
    output logic [7:0]           vga_r_o,
    output logic [7:0]           vga_g_o,
    output logic [7:0]           vga_b_o,
    output logic                 vga_hs_o,
    output logic                 vga_vs_o,
    output logic                 vga_de_o
);

    localparam int H_TOT = calc_h_tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = calc_v_tot(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if ((H_TOT - 1) >= (2 ** PIX_WIDTH) || (V_TOT - 1) >= (2 ** PIX_WIDTH)) begin : g_width_err
            $error("vga_scanout: H_TOT-1 or V_TOT-1 does not fit in PIX_WIDTH bits");
        end
        if (DATA_LAT < 0 || DATA_LAT > 7) begin : g_lat_err
            $error("vga_scanout: DATA_LAT must be in 0..7");
        end
    endgenerate

    // One extra bit so sync-end compares stay exact when a porch is zero.
    localparam int EW = PIX_WIDTH + 1;
    localparam logic [EW-1:0]        H_ACT_E = EW'(H_ACTIVE);
    localparam logic [EW-1:0]        H_SS_E  = EW'(H_ACTIVE + H_FP);
    localparam logic [EW-1:0]        H_SE_E  = EW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [EW-1:0]        V_ACT_E = EW'(V_ACTIVE);
    localparam logic [EW-1:0]        V_SS_E  = EW'(V_ACTIVE + V_FP);
    localparam logic [EW-1:0]        V_SE_E  = EW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [PIX_WIDTH-1:0] H_LAST  = PIX_WIDTH'(H_TOT - 1);
    localparam logic [PIX_WIDTH-1:0] V_LAST  = PIX_WIDTH'(V_TOT - 1);
    localparam logic [PIX_WIDTH-1:0] V_VBL   = PIX_WIDTH'(V_ACTIVE);

    logic [PIX_WIDTH-1:0] h_cnt_q, h_cnt_d;
    logic [PIX_WIDTH-1:0] v_cnt_q, v_cnt_d;
    logic [EW-1:0]        h_ext_s, v_ext_s;
    logic                 de0_s, hs0_s, vs0_s;
    logic                 de_dl_s, hs_dl_s, vs_dl_s;
    rgb_t                 pix_rgb_s;
    rgb_t                 rgb_d, rgb_q;
    logic                 vblank_d, vblank_q;
    logic                 de_q, hs_q, vs_q;

    // Raster counter next state: h wraps every line, v advances on the h wrap.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = {PIX_WIDTH{1'b0}};
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = {PIX_WIDTH{1'b0}};
            end else begin
                v_cnt_d = v_cnt_q + PIX_WIDTH'(1);
            end
        end else begin
            h_cnt_d = h_cnt_q + PIX_WIDTH'(1);
        end
    end

    // Stage-0 enable and syncs, aligned with the coordinates handed to the renderers.
    always_comb begin
        h_ext_s = {1'b0, h_cnt_q};
        v_ext_s = {1'b0, v_cnt_q};
        de0_s   = (h_ext_s < H_ACT_E) && (v_ext_s < V_ACT_E);
        if (h_ext_s >= H_SS_E && h_ext_s < H_SE_E) begin
            hs0_s = HS_POL;
        end else begin
            hs0_s = ~HS_POL;
        end
        if (v_ext_s >= V_SS_E && v_ext_s < V_SE_E) begin
            vs0_s = VS_POL;
        end else begin
            vs0_s = ~VS_POL;
        end
    end

    sig_delay #(
        .WIDTH   (3),
        .DEPTH   (DATA_LAT),
        .RST_VAL ({1'b0, ~HS_POL, ~VS_POL})
    ) u_sync_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({de0_s, hs0_s, vs0_s}),
        .q_o   ({de_dl_s, hs_dl_s, vs_dl_s})
    );

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;

    logic [PIX_WIDTH-1:0] x_dl_s;
    logic [PIX_WIDTH-1:0] bar_s;

    // The x coordinate rides the same delay as de so bars line up with the syncs.
    sig_delay #(
        .WIDTH   (PIX_WIDTH),
        .DEPTH   (DATA_LAT),
        .RST_VAL ({PIX_WIDTH{1'b0}})
    ) u_x_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (h_cnt_q),
        .q_o   (x_dl_s)
    );

    // Colour-bar source; the last bar absorbs any remainder of H_ACTIVE.
    always_comb begin
        bar_s = x_dl_s / PIX_WIDTH'(BAR_W);
        if (bar_s > PIX_WIDTH'(7)) begin
            pix_rgb_s = brick_color(3'd7);
        end else begin
            pix_rgb_s = brick_color(bar_s[2:0]);
        end
    end
`else
    // Renderer source: its colour when it owns the pixel, background otherwise.
    always_comb begin
        if (vga_data_en_i) begin
            pix_rgb_s = vga_data_i;
        end else begin
            pix_rgb_s = BG_COLOR;
        end
    end
`endif

    // Blanking forces black whatever the renderer drives.
    always_comb begin
        if (de_dl_s) begin
            rgb_d = pix_rgb_s;
        end else begin
            rgb_d = 24'h000000;
        end
        vblank_d = (h_cnt_d == {PIX_WIDTH{1'b0}}) && (v_cnt_d == V_VBL);
    end

    // Counters, vblank strobe and pin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q  <= {PIX_WIDTH{1'b0}};
            v_cnt_q  <= {PIX_WIDTH{1'b0}};
            vblank_q <= 1'b0;
            rgb_q    <= 24'h000000;
            de_q     <= 1'b0;
            hs_q     <= ~HS_POL;
            vs_q     <= ~VS_POL;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            vblank_q <= vblank_d;
            rgb_q    <= rgb_d;
            de_q     <= de_dl_s;
            hs_q     <= hs_dl_s;
            vs_q     <= vs_dl_s;
        end
    end

    assign pix_x_o        = h_cnt_q;
    assign pix_y_o        = v_cnt_q;
    assign vblank_start_o = vblank_q;
    assign vga_r_o        = rgb_q.r;
    assign vga_g_o        = rgb_q.g;
    assign vga_b_o        = rgb_q.b;
    assign vga_de_o       = de_q;
    assign vga_hs_o       = hs_q;
    assign vga_vs_o       = vs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Randomized bench for vga_scanout on a 16x8 raster, checked every cycle against a
// frame-arithmetic reference model; includes an asynchronous mid-line reset.
module tb_vga_scanout;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int LAT = 2;
    localparam int PW = 12;
    localparam logic [23:0] BG = 24'h123456;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] pix_x, pix_y;
    logic [23:0]   vga_data = 24'h0;
    logic          vga_data_en = 1'b0;
    logic          vblank_start;
    logic [7:0]    vga_r, vga_g, vga_b;
    logic          vga_hs, vga_vs, vga_de;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int vb_count = 0;
    logic [23:0] data_hist [0:1023];
    logic        en_hist   [0:1023];
    logic [23:0] bricks    [0:7];

    vga_scanout #(
        .PIX_WIDTH (PW),
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HS_POL (1'b1), .VS_POL (1'b1),
        .DATA_LAT (LAT),
        .BG_COLOR (BG)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pix_x_o        (pix_x),
        .pix_y_o        (pix_y),
        .vga_data_i     (vga_data),
        .vga_data_en_i  (vga_data_en),
        .vblank_start_o (vblank_start),
        .vga_r_o        (vga_r),
        .vga_g_o        (vga_g),
        .vga_b_o        (vga_b),
        .vga_hs_o       (vga_hs),
        .vga_vs_o       (vga_vs),
        .vga_de_o       (vga_de)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pix_x"}, 32'(pix_x), 32'd0);
        check_eq({tag, "_pix_y"}, 32'(pix_y), 32'd0);
        check_eq({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
        check_eq({tag, "_de"}, 32'(vga_de), 32'd0);
        check_eq({tag, "_hs"}, 32'(vga_hs), 32'd0);
        check_eq({tag, "_vs"}, 32'(vga_vs), 32'd0);
        check_eq({tag, "_vblank"}, 32'(vblank_start), 32'd0);
    endtask

    // Reference: cycle c shows raster position c, and pins show position c-LAT-1
    // with the renderer data presented during cycle c-1.
    task automatic check_cycle();
        int x, y, p, px, py;
        logic de_e, hs_e, vs_e, vb_e;
        logic [23:0] rgb_e;
        x = cyc % HT;
        y = (cyc / HT) % VT;
        vb_e = (x == 0) && (y == VA);
        de_e = 1'b0; hs_e = 1'b0; vs_e = 1'b0; rgb_e = 24'h0;
        if (cyc >= LAT + 1) begin
            p  = cyc - LAT - 1;
            px = p % HT;
            py = (p / HT) % VT;
            de_e = (px < HA) && (py < VA);
            hs_e = (px >= HA + HF) && (px < HA + HF + HS);
            vs_e = (py >= VA + VF) && (py < VA + VF + VS);
            if (de_e) begin
`ifdef VGA_TEST_PATTERN_EN
                rgb_e = bricks[(px * 8) / HA];
`else
                rgb_e = en_hist[cyc-1] ? data_hist[cyc-1] : BG;
`endif
            end
        end
        check_eq("pix_x", 32'(pix_x), 32'(x));
        check_eq("pix_y", 32'(pix_y), 32'(y));
        check_eq("vblank", 32'(vblank_start), 32'(vb_e));
        check_eq("de", 32'(vga_de), 32'(de_e));
        check_eq("hs", 32'(vga_hs), 32'(hs_e));
        check_eq("vs", 32'(vga_vs), 32'(vs_e));
        check_eq("rgb", 32'({vga_r, vga_g, vga_b}), 32'(rgb_e));
        if (vblank_start) vb_count++;
    endtask

    // Renderer stand-in: data presented now refers to raster position cyc-LAT.
    task automatic drive_cycle();
        int p, px, py;
        logic [23:0] d;
        logic e;
        d = 24'($urandom);
        e = 1'($urandom_range(0, 1));
        p = cyc - LAT;
        if (p >= 0) begin
            px = p % HT;
            py = (p / HT) % VT;
            if (px == 3 && py == 1) begin
                d = 24'hA5B6C7; e = 1'b1;
            end else if (px == 5) begin
                e = 1'b0;
            end else if (px >= HA || py >= VA) begin
                if ($urandom_range(0, 1) == 0) begin
                    d = 24'hFFFFFF; e = 1'b1;
                end
            end
        end
        vga_data = d;
        vga_data_en = e;
        data_hist[cyc] = d;
        en_hist[cyc] = e;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
        drive_cycle();
    endtask

    initial begin
        bricks[0] = 24'h00F0F0; bricks[1] = 24'h0000F0;
        bricks[2] = 24'hF0A000; bricks[3] = 24'hF0F000;
        bricks[4] = 24'h00F000; bricks[5] = 24'hA000F0;
        bricks[6] = 24'hF00000; bricks[7] = 24'h808080;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");

        rst_n = 1'b1;
        cyc = 0;
        check_cycle();
        drive_cycle();
        for (int i = 0; i < 3 * HT * VT; i++) begin
            step();
`ifndef VGA_TEST_PATTERN_EN
            if (cyc == HT + 3 + LAT + 1)
                check_eq("data_a5b6c7", 32'({vga_r, vga_g, vga_b}), 32'h00A5B6C7);
`endif
        end
        check_eq("vblank_per_3frames", 32'(vb_count), 32'd3);

        for (int i = 0; i < HT * VT && (cyc % (HT * VT)) != (2 * HT + 6); i++) begin
            step();
        end
        check_eq("at_mid_line_x", 32'(pix_x), 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_edge");

        rst_n = 1'b1;
        cyc = 0;
        check_cycle();
        drive_cycle();
        for (int i = 0; i < 2 * HT * VT; i++) begin
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
